// File: rtl/nunchuck_pkg.sv
// Shared types and helpers for the nunchuck input conditioner.
// Holds the FSM state type, the stick sample type and the per-axis centring/saturation function.
package nunchuck_pkg;

  typedef enum logic [1:0] {SETTLE, ACC, RUN} cond_state_t;

  typedef logic signed [7:0] stick_t;

  localparam int STICK_MAX = 127;

  // Centre one axis, clamp to +/-STICK_MAX and squash small deflections to zero.
  function automatic stick_t condition_axis(input logic [7:0] raw, input logic [7:0] centre,
                                            input int unsigned deadzone);
    logic signed [8:0] d;
    logic signed [8:0] sat;
    logic [8:0]        mag;
    d = $signed({1'b0, raw}) - $signed({1'b0, centre});
    if (int'(d) > STICK_MAX) begin
      sat = 9'(STICK_MAX);
    end else if (int'(d) < -STICK_MAX) begin
      sat = 9'(-STICK_MAX);
    end else begin
      sat = d;
    end
    mag = sat[8] ? 9'(-sat) : 9'(sat);
    if ({23'b0, mag} < deadzone) begin
      return '0;
    end
    return $signed(sat[7:0]);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Counter-based debouncer: the stable level follows raw only after raw has differed
// for DEBOUNCE_CYCLES consecutive cycles; rise pulses for one cycle on a 0->1 flip.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clkin,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= raw;
        rise  <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nunchuck_input_conditioner.sv
// Per-player nunchuck conditioner: calibrates the stick rest position, then reports centred,
// saturated, dead-zoned stick values and debounced Z/C buttons with press pulses.
module nunchuck_input_conditioner
  import nunchuck_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SAMPLE_DIV      = 50000,
  parameter int unsigned SETTLE_TICKS    = 64,
  parameter int unsigned CAL_LOG2        = 4,
  parameter int unsigned DEADZONE        = 8
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic [7:0]        stick_x_raw,
  input  logic [7:0]        stick_y_raw,
  input  logic              z_raw,
  input  logic              c_raw,
  input  logic              recal,
  output logic signed [7:0] stick_x,
  output logic signed [7:0] stick_y,
  output logic              z_btn,
  output logic              c_btn,
  output logic              z_press,
  output logic              c_press,
  output logic              cal_done
);

  localparam int unsigned DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned SETTLE_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam int unsigned SAMP_W   = (CAL_LOG2 > 0) ? CAL_LOG2 : 1;
  localparam int unsigned SUM_W    = 8 + CAL_LOG2;

  localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);
  localparam logic [SAMP_W-1:0]   SAMP_LAST   = SAMP_W'((1 << CAL_LOG2) - 1);

  cond_state_t         state;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SAMP_W-1:0]   samp_cnt;
  logic [SUM_W-1:0]    sum_x;
  logic [SUM_W-1:0]    sum_y;
  logic [SUM_W-1:0]    next_sum_x;
  logic [SUM_W-1:0]    next_sum_y;
  logic [7:0]          centre_x;
  logic [7:0]          centre_y;
  logic                z_level;
  logic                z_rise;
  logic                c_level;
  logic                c_rise;

  assign tick       = (div_cnt == DIV_LAST);
  assign next_sum_x = sum_x + SUM_W'(stick_x_raw);
  assign next_sum_y = sum_y + SUM_W'(stick_y_raw);

  // A recalibration restarts the sample grid so the settle period is a full one.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (recal || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      centre_x   <= 8'd128;
      centre_y   <= 8'd128;
      stick_x    <= '0;
      stick_y    <= '0;
    end else if (recal) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      stick_x    <= '0;
      stick_y    <= '0;
    end else begin
      stick_x <= '0;
      stick_y <= '0;
      unique case (state)
        SETTLE: begin
          if (tick) begin
            if (settle_cnt == SETTLE_LAST) begin
              state      <= ACC;
              settle_cnt <= '0;
              samp_cnt   <= '0;
              sum_x      <= '0;
              sum_y      <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        ACC: begin
          if (tick) begin
            sum_x <= next_sum_x;
            sum_y <= next_sum_y;
            if (samp_cnt == SAMP_LAST) begin
              // Top 8 bits of the full sum are the average.
              centre_x <= next_sum_x[SUM_W-1 -: 8];
              centre_y <= next_sum_y[SUM_W-1 -: 8];
              state    <= RUN;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          stick_x <= condition_axis(stick_x_raw, centre_x, DEADZONE);
          stick_y <= condition_axis(stick_y_raw, centre_y, DEADZONE);
        end
        default: state <= SETTLE;
      endcase
    end
  end

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_z_debounce (
    .clkin(clkin),
    .rst  (rst),
    .raw  (z_raw),
    .level(z_level),
    .rise (z_rise)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_c_debounce (
    .clkin(clkin),
    .rst  (rst),
    .raw  (c_raw),
    .level(c_level),
    .rise (c_rise)
  );

  // A flip that happened before RUN has already pulsed, so a held button stays silent.
  assign cal_done = (state == RUN);
  assign z_btn    = z_level & cal_done;
  assign c_btn    = c_level & cal_done;
  assign z_press  = z_rise & cal_done;
  assign c_press  = c_rise & cal_done;

endmodule

// File: tb/tb_nunchuck_input_conditioner.sv
// Self-checking bench: stick vector table, hand-written button/recal/reset sequences and a
// randomized phase checked against a behavioural model of centring and debouncing.
module tb_nunchuck_input_conditioner;

  localparam int DEB = 4;
  localparam int DIV = 2;
  localparam int SET = 2;
  localparam int CLG = 2;
  localparam int DZ  = 8;
  localparam int CAL_EDGES = (SET + (1 << CLG)) * DIV;

  logic              clkin = 1'b0;
  logic              rst;
  logic [7:0]        stick_x_raw;
  logic [7:0]        stick_y_raw;
  logic              z_raw;
  logic              c_raw;
  logic              recal;
  logic signed [7:0] stick_x;
  logic signed [7:0] stick_y;
  logic              z_btn;
  logic              c_btn;
  logic              z_press;
  logic              c_press;
  logic              cal_done;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  nunchuck_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SAMPLE_DIV     (DIV),
    .SETTLE_TICKS   (SET),
    .CAL_LOG2       (CLG),
    .DEADZONE       (DZ)
  ) dut (
    .clkin      (clkin),
    .rst        (rst),
    .stick_x_raw(stick_x_raw),
    .stick_y_raw(stick_y_raw),
    .z_raw      (z_raw),
    .c_raw      (c_raw),
    .recal      (recal),
    .stick_x    (stick_x),
    .stick_y    (stick_y),
    .z_btn      (z_btn),
    .c_btn      (c_btn),
    .z_press    (z_press),
    .c_press    (c_press),
    .cal_done   (cal_done)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int x;
    int y;
    int ex;
    int ey;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string pre);
    check({pre, "_stick_x"}, int'(stick_x), 0);
    check({pre, "_stick_y"}, int'(stick_y), 0);
    check({pre, "_z_btn"}, int'(z_btn), 0);
    check({pre, "_c_btn"}, int'(c_btn), 0);
    check({pre, "_z_press"}, int'(z_press), 0);
    check({pre, "_c_press"}, int'(c_press), 0);
    check({pre, "_cal_done"}, int'(cal_done), 0);
  endtask

  // Reference: centre, clamp to +/-127, then dead-zone.
  function automatic int ref_axis(input int raw, input int centre);
    int d;
    d = raw - centre;
    if (d > 127) d = 127;
    if (d < -127) d = -127;
    if ((d < 0 ? -d : d) < DZ) d = 0;
    return d;
  endfunction

  // Reference debounce: level flips once the last DEB raw samples all disagree with it.
  function automatic bit all_differ(input bit hist[$], input bit lvl);
    foreach (hist[i]) if (hist[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_cal(input string name, output int n);
    n = 0;
    while (!cal_done && n < 200) begin
      step();
      n++;
    end
    check(name, n, CAL_EDGES);
  endtask

  initial begin
    vec_t vecs[$];
    int   n;
    int   cnt;
    bit   seen;
    bit   early;
    bit   zh[$];
    bit   ch[$];
    bit   zl;
    bit   cl;
    bit   zexp_p;
    bit   cexp_p;
    int   zhold;
    int   chold;

    // Centres are 130 / 120 after the first calibration.
    vecs.push_back('{250, 120, 120, 0});
    vecs.push_back('{0, 255, -127, 127});
    vecs.push_back('{135, 0, 0, -120});
    vecs.push_back('{138, 127, 8, 0});
    vecs.push_back('{122, 128, -8, 8});
    vecs.push_back('{123, 112, 0, -8});
    vecs.push_back('{255, 113, 125, 0});
    vecs.push_back('{2, 247, -127, 127});

    rst = 1'b1; recal = 1'b0;
    stick_x_raw = 8'd130; stick_y_raw = 8'd120;
    z_raw = 1'b1; c_raw = 1'b0;
    #12;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    cyc = 0;

    // Calibration with Z held throughout: no pulse, level hidden until RUN.
    n = 0; seen = 1'b0; early = 1'b0;
    while (!cal_done && n < 200) begin
      step();
      n++;
      if (z_press) seen = 1'b1;
      if (!cal_done && z_btn) early = 1'b1;
    end
    check("cal_latency", n, CAL_EDGES);
    check("z_btn_hidden_pre_run", int'(early), 0);
    check("z_held_in_run", int'(z_btn), 1);
    check("z_press_while_held", int'(seen | z_press), 0);
    step();
    check("centred_x", int'(stick_x), 0);
    check("centred_y", int'(stick_y), 0);

    foreach (vecs[i]) begin
      stick_x_raw = 8'(vecs[i].x);
      stick_y_raw = 8'(vecs[i].y);
      step();
      check($sformatf("vec%0d_x", i), int'(stick_x), vecs[i].ex);
      check($sformatf("vec%0d_y", i), int'(stick_y), vecs[i].ey);
    end

    // Release Z, then press again: exactly one pulse.
    z_raw = 1'b0;
    repeat (6) step();
    check("z_released", int'(z_btn), 0);
    z_raw = 1'b1; cnt = 0;
    repeat (8) begin step(); cnt += int'(z_press); end
    check("z_press_count", cnt, 1);
    check("z_pressed_level", int'(z_btn), 1);
    z_raw = 1'b0;
    repeat (6) step();

    // C glitch of DEB-1 cycles is rejected; DEB+ cycles gives one pulse.
    c_raw = 1'b1; seen = 1'b0;
    repeat (DEB - 1) begin step(); seen |= c_btn | c_press; end
    c_raw = 1'b0;
    repeat (3) begin step(); seen |= c_btn | c_press; end
    check("c_short_rejected", int'(seen), 0);
    c_raw = 1'b1; cnt = 0;
    repeat (8) begin step(); cnt += int'(c_press); end
    check("c_press_count", cnt, 1);
    check("c_pressed_level", int'(c_btn), 1);
    c_raw = 1'b0;
    repeat (6) step();
    check("c_released", int'(c_btn), 0);

    // Randomized RUN phase against the model.
    zl = 1'b0; cl = 1'b0; zhold = 0; chold = 0;
    repeat (DEB) begin zh.push_back(1'b0); ch.push_back(1'b0); end
    for (int i = 0; i < 400; i++) begin
      if (zhold == 0) begin z_raw = 1'($urandom); zhold = $urandom_range(1, 7); end
      if (chold == 0) begin c_raw = 1'($urandom); chold = $urandom_range(1, 7); end
      zhold--; chold--;
      stick_x_raw = 8'($urandom);
      stick_y_raw = 8'($urandom);
      step();
      zh.push_back(z_raw); void'(zh.pop_front());
      ch.push_back(c_raw); void'(ch.pop_front());
      zexp_p = 1'b0; cexp_p = 1'b0;
      if (all_differ(zh, zl)) begin zl = ~zl; zexp_p = zl; end
      if (all_differ(ch, cl)) begin cl = ~cl; cexp_p = cl; end
      check("rand_x", int'(stick_x), ref_axis(int'(stick_x_raw), 130));
      check("rand_y", int'(stick_y), ref_axis(int'(stick_y_raw), 120));
      check("rand_z_btn", int'(z_btn), int'(zl));
      check("rand_z_press", int'(z_press), int'(zexp_p));
      check("rand_c_btn", int'(c_btn), int'(cl));
      check("rand_c_press", int'(c_press), int'(cexp_p));
    end
    z_raw = 1'b0; c_raw = 1'b0;
    repeat (8) step();

    // Recal coinciding with a tick.
    stick_x_raw = 8'd200; stick_y_raw = 8'd60;
    step();
    check("pre_recal_x", int'(stick_x), 70);
    while (((cyc + 1) % DIV) != 0) step();
    recal = 1'b1;
    step();
    recal = 1'b0;
    check("recal_cal_done", int'(cal_done), 0);
    check("recal_stick_x", int'(stick_x), 0);
    n = 0;
    while (!cal_done && n < 200) begin step(); n++; end
    check("recal_completes", int'(cal_done), 1);
    step();
    check("recal_centre_x", int'(stick_x), 0);
    check("recal_centre_y", int'(stick_y), 0);
    stick_x_raw = 8'd210; stick_y_raw = 8'd40;
    step();
    check("recal_dx", int'(stick_x), 10);
    check("recal_dy", int'(stick_y), -20);

    // Async reset mid-debounce in RUN with live outputs.
    stick_x_raw = 8'd250; c_raw = 1'b1;
    repeat (6) step();
    check("live_x", int'(stick_x), 50);
    check("live_c", int'(c_btn), 1);
    #3 rst = 1'b1;
    #1 check_all_zero("rst_run");
    @(posedge clkin);
    #1 rst = 1'b0;
    cyc = 0; c_raw = 1'b0;
    stick_x_raw = 8'd130; stick_y_raw = 8'd120;

    // Async reset mid-ACC, then calibration restarts from SETTLE.
    repeat (SET * DIV + 3) step();
    rst = 1'b1;
    #1 check_all_zero("rst_acc");
    #5 rst = 1'b0;
    wait_cal("cal_after_rst", n);
    step();
    check("post_rst_x", int'(stick_x), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
